// File: rtl/reg_to_uart_if.sv
// Handshake bundle between the register bank, reg_to_uart and the UART TX core.
// slave is the reg_to_uart view; master is the environment view.
interface reg_to_uart_if #(
  parameter int unsigned N = 8
);
  logic           enable;
  logic           load;
  logic [N/2-1:0] bus_0;
  logic [N/2-1:0] bus_1;
  logic           busy;
  logic           ready;
  logic           send;
  logic [N-1:0]   data;
  logic           err;

  modport slave (
    input  enable,
    input  load,
    input  bus_0,
    input  bus_1,
    input  busy,
    output ready,
    output send,
    output data,
    output err
  );

  modport master (
    output enable,
    output load,
    output bus_0,
    output bus_1,
    output busy,
    input  ready,
    input  send,
    input  data,
    input  err
  );
endinterface

// File: rtl/reg_to_uart.sv
// Packs two register nibbles into a word and hands it to the UART TX with a send/busy handshake.
// Optional REG_TO_UART_HEX_EN (N=8 only): each load sends two upper-case ASCII hex characters.
module reg_to_uart #(
  parameter int unsigned N           = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  reg_to_uart_if.slave io
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            send, err;

`ifdef REG_TO_UART_HEX_EN
  logic           chr_q, chr_d;
  logic [N/2-1:0] nib_lo_q, nib_lo_d;

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      cnt_q    <= '0;
`ifdef REG_TO_UART_HEX_EN
      chr_q    <= 1'b0;
      nib_lo_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
`ifdef REG_TO_UART_HEX_EN
      chr_q    <= chr_d;
      nib_lo_q <= nib_lo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    send    = 1'b0;
    err     = 1'b0;
`ifdef REG_TO_UART_HEX_EN
    chr_d    = chr_q;
    nib_lo_d = nib_lo_q;
`endif
    if (!io.enable) begin
      // data is deliberately retained; only the control path is parked
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (io.load && !io.busy) begin
`ifdef REG_TO_UART_HEX_EN
            data_d   = to_hex(io.bus_0);
            nib_lo_d = io.bus_1;
            chr_d    = 1'b0;
`else
            data_d   = {io.bus_0, io.bus_1};
`endif
            state_d  = StSend;
          end
        end
        StSend: begin
          send    = 1'b1;
          cnt_d   = '0;
          state_d = StWaitAck;
        end
        StWaitAck: begin
          // busy arriving on the final count still wins over the timeout
          if (io.busy) begin
            state_d = StWaitDone;
          end else if (cnt_q == CntMax) begin
            err     = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!io.busy) begin
`ifdef REG_TO_UART_HEX_EN
            if (!chr_q) begin
              chr_d   = 1'b1;
              data_d  = to_hex(nib_lo_q);
              state_d = StSend;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign io.ready = (state_q == StIdle) & io.enable & ~io.busy & ~rst;
  assign io.send  = send;
  assign io.err   = err;
  assign io.data  = data_q;

endmodule

// File: tb/tb_reg_to_uart.sv
// Directed bench for reg_to_uart: a word-level scoreboard checks every send pulse and the held
// data word; directed checks pin handshake timing, timeout, enable and async reset behaviour.
module tb_reg_to_uart;
  localparam int unsigned N          = 8;
  localparam int unsigned AckTimeout = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_to_uart_if #(.N(N)) ifc ();

  logic busy_tx  = 1'b0;
  logic busy_man = 1'b0;
  assign ifc.busy = busy_tx | busy_man;

  reg_to_uart #(
    .N          (N),
    .ACK_TIMEOUT(AckTimeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (ifc)
  );

  int tests = 0;
  int fails = 0;
  int sends_seen = 0;
  int errs_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_data = 8'h00;
  bit hold_chk = 1'b0;

  int tx_delay = 2;
  int tx_len = 10;
  bit tx_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    int v;
    v = n;
    if (v < 10) return 8'(48 + v);   // '0' + n
    return 8'(65 + v - 10);          // 'A' + n - 10
  endfunction

  // Scoreboard: every send pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.send) begin
        sends_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_send: got data %0h with no send expected", ifc.data);
        end else begin
          check("send_data", ifc.data, exp_q.pop_front());
        end
      end
      if (ifc.err) errs_seen++;
      if (hold_chk) check("data_hold", ifc.data, model_data);
    end
  end

  // UART TX model: busy rises tx_delay cycles after a send pulse, for tx_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.send && tx_en) begin
        repeat (tx_delay) @(posedge clk);
        #2 busy_tx = 1'b1;
        repeat (tx_len) @(posedge clk);
        #2 busy_tx = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] hi, input logic [3:0] lo);
    ifc.bus_0 = hi;
    ifc.bus_1 = lo;
    ifc.load  = 1'b1;
    tick();
    ifc.load  = 1'b0;
  endtask

  // which: 0 send, 1 busy, 2 err, 3 ready. Returns negedges waited.
  task automatic wait_sig(input string name, input int which, input logic val, input int max,
                          output int cyc);
    logic s;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      case (which)
        0: s = ifc.send;
        1: s = ifc.busy;
        2: s = ifc.err;
        default: s = ifc.ready;
      endcase
      if (s === val) break;
      if (cyc >= max) begin
        tests++;
        fails++;
        $display("FAIL %s: timed out after %0d cycles waiting for %0b", name, cyc, val);
        break;
      end
    end
  endtask

  int c;

  initial begin
    rst        = 1'b1;
    ifc.enable = 1'b1;
    ifc.load   = 1'b0;
    ifc.bus_0  = '0;
    ifc.bus_1  = '0;
    #2;
    check("rst_ready", ifc.ready, 0);
    check("rst_send", ifc.send, 0);
    check("rst_err", ifc.err, 0);
    check("rst_data", ifc.data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ifc.ready, 1);
    tick();

`ifndef REG_TO_UART_HEX_EN
    hold_chk = 1'b1;

    // Basic send
    exp_q.push_back(8'hA5);
    load_word(4'hA, 4'h5);
    model_data = 8'hA5;
    @(negedge clk);
    check("send_one_cycle_after_load", ifc.send, 1);
    check("basic_data", ifc.data, 8'hA5);
    check("basic_ready_low", ifc.ready, 0);
    @(negedge clk);
    check("send_single_pulse", ifc.send, 0);
    wait_sig("basic_busy_rise", 1, 1'b1, 20, c);
    wait_sig("basic_busy_fall", 1, 1'b0, 30, c);
    check("ready_low_as_busy_falls", ifc.ready, 0);
    @(negedge clk);
    check("ready_after_busy_fall", ifc.ready, 1);
    check("basic_no_err", errs_seen, 0);

    // Dropped load while busy in IDLE
    tick();
    busy_man = 1'b1;
    ifc.bus_0 = 4'h1;
    ifc.bus_1 = 4'h2;
    ifc.load  = 1'b1;
    @(negedge clk);
    check("ready_low_busy_idle", ifc.ready, 0);
    tick();
    ifc.load = 1'b0;
    busy_man = 1'b0;
    repeat (3) tick();

    // Load during WAIT_DONE and on the busy-fall cycle are both dropped
    exp_q.push_back(8'h3C);
    load_word(4'h3, 4'hC);
    model_data = 8'h3C;
    wait_sig("drop_busy_rise", 1, 1'b1, 20, c);
    tick();
    load_word(4'h7, 4'hE);
    wait_sig("drop_busy_fall", 1, 1'b0, 30, c);
    ifc.bus_0 = 4'h9;
    ifc.bus_1 = 4'h9;
    ifc.load  = 1'b1;
    tick();
    ifc.load = 1'b0;
    @(negedge clk);
    check("ready_after_drop", ifc.ready, 1);
    repeat (5) tick();
    check("dropped_loads_no_send", sends_seen, 2);

    // Ack timeout
    tx_en = 1'b0;
    exp_q.push_back(8'h5A);
    load_word(4'h5, 4'hA);
    model_data = 8'h5A;
    wait_sig("to_send", 0, 1'b1, 3, c);
    check("to_send_latency", c, 1);
    wait_sig("to_err", 2, 1'b1, 30, c);
    check("err_16_after_send", c, 16);
    @(negedge clk);
    check("err_single_pulse", ifc.err, 0);
    check("ready_after_timeout", ifc.ready, 1);
    check("timeout_err_count", errs_seen, 1);

    // busy rising on the last count cycle is success
    tick();
    tx_en = 1'b1;
    tx_delay = 16;
    tx_len = 3;
    exp_q.push_back(8'h66);
    load_word(4'h6, 4'h6);
    model_data = 8'h66;
    wait_sig("late_busy_rise", 1, 1'b1, 40, c);
    wait_sig("late_busy_fall", 1, 1'b0, 10, c);
    @(negedge clk);
    check("late_ack_ready", ifc.ready, 1);
    check("late_ack_no_err", errs_seen, 1);

    // one cycle later than that is a timeout
    tick();
    tx_delay = 17;
    exp_q.push_back(8'h77);
    load_word(4'h7, 4'h7);
    model_data = 8'h77;
    wait_sig("too_late_err", 2, 1'b1, 30, c);
    check("too_late_err_cycle", c, 17);
    wait_sig("too_late_busy_fall", 1, 1'b0, 10, c);
    tick();
    tick();
    check("too_late_err_count", errs_seen, 2);

    // Enable dropped in WAIT_ACK
    tx_en = 1'b0;
    tx_delay = 2;
    tx_len = 10;
    exp_q.push_back(8'h88);
    load_word(4'h8, 4'h8);
    model_data = 8'h88;
    wait_sig("en_send", 0, 1'b1, 3, c);
    repeat (3) @(negedge clk);
    tick();
    ifc.enable = 1'b0;
    @(negedge clk);
    check("en_low_err", ifc.err, 0);
    check("en_low_ready", ifc.ready, 0);
    tick();
    @(negedge clk);
    check("en_low_ready_idle", ifc.ready, 0);
    tick();
    ifc.enable = 1'b1;
    @(negedge clk);
    check("ready_after_enable", ifc.ready, 1);
    repeat (20) tick();
    check("enable_drop_no_err", errs_seen, 2);

    // Async reset in WAIT_DONE
    tx_en = 1'b1;
    exp_q.push_back(8'h99);
    load_word(4'h9, 4'h9);
    model_data = 8'h99;
    wait_sig("rst_busy_rise", 1, 1'b1, 20, c);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    model_data = 8'h00;
    #1;
    check("rst_async_data", ifc.data, 0);
    check("rst_async_send", ifc.send, 0);
    check("rst_async_ready", ifc.ready, 0);
    check("rst_async_err", ifc.err, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    wait_sig("rst_frame_done", 1, 1'b0, 20, c);
    @(negedge clk);
    check("ready_after_rst_frame", ifc.ready, 1);
    repeat (3) tick();
    check("total_sends", sends_seen, 7);
    check("queue_drained", exp_q.size(), 0);
`else
    // Hex mode: 3C -> '3' then 'C'
    tx_en = 1'b1;
    tx_delay = 2;
    tx_len = 4;
    exp_q.push_back(hex_char(4'h3));
    exp_q.push_back(hex_char(4'hC));
    load_word(4'h3, 4'hC);
    @(negedge clk);
    check("hex_first_send", ifc.send, 1);
    check("hex_first_char", ifc.data, 8'h33);
    wait_sig("hex_busy0_rise", 1, 1'b1, 20, c);
    wait_sig("hex_busy0_fall", 1, 1'b0, 20, c);
    check("hex_ready_low_mid", ifc.ready, 0);
    wait_sig("hex_second_send", 0, 1'b1, 5, c);
    check("hex_second_char", ifc.data, 8'h43);
    check("hex_ready_low_send", ifc.ready, 0);
    wait_sig("hex_busy1_rise", 1, 1'b1, 20, c);
    wait_sig("hex_busy1_fall", 1, 1'b0, 20, c);
    check("hex_ready_low_last", ifc.ready, 0);
    @(negedge clk);
    check("hex_ready_after", ifc.ready, 1);
    check("hex_sends", sends_seen, 2);

    // Hex timeout on character 0 aborts character 1
    tick();
    tx_en = 1'b0;
    exp_q.push_back(hex_char(4'hA));
    load_word(4'hA, 4'hB);
    wait_sig("hex_to_err", 2, 1'b1, 30, c);
    check("hex_to_err_cycle", c, 17);
    repeat (30) tick();
    check("hex_to_sends", sends_seen, 3);
    check("hex_to_errs", errs_seen, 1);
    check("hex_queue_drained", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
